// File: rtl/lut_neuron_array_if.sv
// Stream, output and configuration signals of lut_neuron_array bundled as one port.
// The cfg_re/cfg_rdata pair exists only when LUT_READBACK_EN is defined.
interface lut_neuron_array_if #(
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  parameter int NEURONS  = 4
);
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [NEURONS*FANIN-1:0]     in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NEURONS*OUT_BITS-1:0]  out_data;
  logic                         cfg_we;
  logic [NW-1:0]                cfg_neuron;
  logic [FANIN-1:0]             cfg_addr;
  logic [OUT_BITS-1:0]          cfg_data;
`ifdef LUT_READBACK_EN
  logic                         cfg_re;
  logic [OUT_BITS-1:0]          cfg_rdata;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data, cfg_re,
    input  in_ready, out_valid, out_data, cfg_rdata
  );
  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data, cfg_re,
    output in_ready, out_valid, out_data, cfg_rdata
  );
`else
  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/lut_neuron_array.sv
// Array of runtime-programmable truth-table neurons with a registered valid/ready output.
// Optional table readback port is enabled by defining LUT_READBACK_EN.
module lut_neuron_array #(
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  parameter int NEURONS  = 4
) (
  input logic              clk,
  input logic              rst,
  lut_neuron_array_if.slave bus
);
  localparam int NW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int DEPTH = 1 << FANIN;
  localparam logic [NW:0] NLIMIT = (NW+1)'(NEURONS);

  logic [OUT_BITS-1:0]         lutMem [NEURONS][DEPTH];
  logic                        outValid;
  logic [NEURONS*OUT_BITS-1:0] outData;
  logic [NEURONS*OUT_BITS-1:0] lookupVec;
  logic                        accept;
  logic                        cfgInRange;
  logic                        cfgHit;

  // Tables were generated with the input MSB first, so the index is the reversed input.
  function automatic logic [FANIN-1:0] bitRev(input logic [FANIN-1:0] x);
    logic [FANIN-1:0] r;
    r = '0;
    for (int i = 0; i < FANIN; i++) r[i] = x[FANIN-1-i];
    return r;
  endfunction

  assign cfgInRange    = ({1'b0, bus.cfg_neuron} < NLIMIT);
  assign cfgHit        = bus.cfg_we && cfgInRange;
  assign bus.in_ready  = (!outValid || bus.out_ready) && !bus.cfg_we;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;

  always_comb begin
    lookupVec = '0;
    for (int n = 0; n < NEURONS; n++) begin
      lookupVec[n*OUT_BITS +: OUT_BITS] = lutMem[n][bitRev(bus.in_data[n*FANIN +: FANIN])];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outData  <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        for (int d = 0; d < DEPTH; d++) lutMem[n][d] <= '0;
      end
    end else begin
      if (accept) begin
        outData  <= lookupVec;
        outValid <= 1'b1;
      end else if (bus.out_ready) begin
        outValid <= 1'b0;
      end
      if (cfgHit) lutMem[bus.cfg_neuron][bus.cfg_addr] <= bus.cfg_data;
    end
  end

`ifdef LUT_READBACK_EN
  logic [OUT_BITS-1:0] cfgRdata;

  assign bus.cfg_rdata = cfgRdata;

  // Reads sample the table before any same-edge write lands, so they return the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfgRdata <= '0;
    end else if (bus.cfg_re) begin
      cfgRdata <= cfgInRange ? lutMem[bus.cfg_neuron][bus.cfg_addr] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_lut_neuron_array.sv
// Directed self-checking bench for lut_neuron_array, main 6x1x4 instance plus a 2x2x3 instance
// used for the out-of-range neuron case.
module tb_lut_neuron_array;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  lut_neuron_array_if #(.FANIN(6), .OUT_BITS(1), .NEURONS(4)) bus ();
  lut_neuron_array #(.FANIN(6), .OUT_BITS(1), .NEURONS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  lut_neuron_array_if #(.FANIN(2), .OUT_BITS(2), .NEURONS(3)) obus ();
  lut_neuron_array #(.FANIN(2), .OUT_BITS(2), .NEURONS(3)) dutOdd (
    .clk(clk), .rst(rst), .bus(obus)
  );

  logic [23:0] vecs [8];
  logic [3:0]  exps [8];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input logic [1:0] n, input logic [5:0] a, input logic d);
    bus.cfg_we = 1'b1; bus.cfg_neuron = n; bus.cfg_addr = a; bus.cfg_data = d;
    cycle();
    bus.cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [23:0] data, input logic [3:0] exp, input string tag);
    int n;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = data;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    cycle();
    bus.in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput(tag, 32'(bus.out_data), 32'(exp));
  endtask

  task automatic oddWrite(input logic [1:0] n, input logic [1:0] a, input logic [1:0] d);
    obus.cfg_we = 1'b1; obus.cfg_neuron = n; obus.cfg_addr = a; obus.cfg_data = d;
    cycle();
    obus.cfg_we = 1'b0;
  endtask

  task automatic oddLookup(input logic [1:0] i, input logic [5:0] exp, input string tag);
    obus.out_ready = 1'b1; obus.in_valid = 1'b1; obus.in_data = {i, i, i};
    #1;
    checkOutput({tag, "_ready"}, 32'(obus.in_ready), 32'd1);
    cycle();
    obus.in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(obus.out_valid), 32'd1);
    checkOutput(tag, 32'(obus.out_data), 32'(exp));
  endtask

  initial begin
    int          sent;
    int          recv;
    logic        holdPending;
    logic [3:0]  heldData;
    logic        ov;
    logic [3:0]  od;
    logic        orr;
    logic        accepted;

    vecs[0] = {6'd0, 6'd0, 6'd0, 6'b001001};                      exps[0] = 4'b0001;
    vecs[1] = {6'd0, 6'd0, 6'b000001, 6'd0};                      exps[1] = 4'b0010;
    vecs[2] = {6'd0, 6'b000010, 6'd0, 6'd0};                      exps[2] = 4'b0100;
    vecs[3] = {6'b000011, 6'd0, 6'd0, 6'd0};                      exps[3] = 4'b1000;
    vecs[4] = {6'b000011, 6'd0, 6'd0, 6'b100101};                 exps[4] = 4'b1001;
    vecs[5] = {6'b000001, 6'b000001, 6'b000001, 6'b000001};       exps[5] = 4'b0010;
    vecs[6] = 24'd0;                                              exps[6] = 4'b0000;
    vecs[7] = {6'b000011, 6'b000010, 6'b000001, 6'b001001};       exps[7] = 4'b1111;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    obus.in_valid = 1'b0; obus.in_data = '0; obus.out_ready = 1'b1;
    obus.cfg_we = 1'b0; obus.cfg_neuron = '0; obus.cfg_addr = '0; obus.cfg_data = '0;
`ifdef LUT_READBACK_EN
    bus.cfg_re = 1'b0;
    obus.cfg_re = 1'b0;
`endif
    repeat (3) cycle();
    rst = 1'b0;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(24'd0, 4'b0000, "zero_in");

    // Neuron 0 entries 36 and 41 are the reversed forms of inputs 001001 and 100101.
    writeEntry(2'd0, 6'd36, 1'b1);
    writeEntry(2'd0, 6'd41, 1'b1);
    applyStimulus({18'd0, 6'b001001}, 4'b0001, "n0_001001");
    applyStimulus({18'd0, 6'b010101}, 4'b0000, "n0_010101");
    applyStimulus({18'd0, 6'b100101}, 4'b0001, "n0_100101");
    applyStimulus({12'd0, 6'b001001, 6'b001001}, 4'b0001, "n1_isolated");
    applyStimulus({18'd0, 6'b100100}, 4'b0000, "n0_unreversed");

    writeEntry(2'd1, 6'd32, 1'b1);
    writeEntry(2'd2, 6'd16, 1'b1);
    writeEntry(2'd3, 6'd48, 1'b1);

    sent = 0; recv = 0; holdPending = 1'b0; heldData = '0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      bus.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      bus.in_valid  = (sent < 8);
      bus.in_data   = vecs[(sent < 8) ? sent : 7];
      #1;
      if (holdPending) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_data", 32'(bus.out_data), 32'(heldData));
      end
      holdPending = 1'b0;
      ov = bus.out_valid; od = bus.out_data; orr = bus.out_ready;
      accepted = bus.in_valid && bus.in_ready;
      checkOutput("stream_ready", 32'(bus.in_ready), 32'(!ov || orr));
      if (ov && orr) begin
        checkOutput($sformatf("stream_out%0d", recv), 32'(od), 32'(exps[recv]));
        recv++;
      end else if (ov) begin
        holdPending = 1'b1;
        heldData = od;
      end
      if (accepted) sent++;
      cycle();
    end
    bus.in_valid = 1'b0;
    checkOutput("stream_count", 32'(recv), 32'd8);
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_hold", 32'(bus.out_data), 32'hF);

    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = {4{6'b010101}};
    cycle();
    checkOutput("held_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("held_data", 32'(bus.out_data), 32'd0);
    bus.cfg_we = 1'b1; bus.cfg_neuron = 2'd0; bus.cfg_addr = 6'd42; bus.cfg_data = 1'b1;
    cycle();
    checkOutput("write_stall_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("write_stall_data", 32'(bus.out_data), 32'd0);
    bus.out_ready = 1'b1; bus.cfg_neuron = 2'd1;
    #1;
    checkOutput("we_blocks_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    bus.cfg_we = 1'b0;
    checkOutput("we_no_accept", 32'(bus.out_valid), 32'd0);
    checkOutput("we_data_hold", 32'(bus.out_data), 32'd0);
    applyStimulus({4{6'b010101}}, 4'b0011, "after_write");

    // Entry 2 is the reversed form of input 01 on the two-bit neurons.
    for (int a = 0; a < 4; a++) oddWrite(2'd3, 2'(a), 2'b11);
    oddWrite(2'd2, 2'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      oddLookup(2'(i), (i == 1) ? 6'b100000 : 6'b000000, $sformatf("oob_in%0d", i));
    end

`ifdef LUT_READBACK_EN
    writeEntry(2'd3, 6'd63, 1'b1);
    bus.cfg_re = 1'b1; bus.cfg_neuron = 2'd3; bus.cfg_addr = 6'd63;
    #1;
    checkOutput("rb_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    bus.cfg_re = 1'b0; bus.cfg_addr = 6'd0;
    checkOutput("rb_data", 32'(bus.cfg_rdata), 32'd1);
    cycle();
    checkOutput("rb_hold", 32'(bus.cfg_rdata), 32'd1);
    bus.cfg_re = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 6'd62; bus.cfg_data = 1'b1;
    cycle();
    bus.cfg_we = 1'b0;
    checkOutput("rb_old_value", 32'(bus.cfg_rdata), 32'd0);
    cycle();
    bus.cfg_re = 1'b0;
    checkOutput("rb_new_value", 32'(bus.cfg_rdata), 32'd1);
    obus.cfg_re = 1'b1; obus.cfg_neuron = 2'd2; obus.cfg_addr = 2'd2;
    cycle();
    checkOutput("rb_odd_data", 32'(obus.cfg_rdata), 32'd2);
    obus.cfg_neuron = 2'd3;
    cycle();
    obus.cfg_re = 1'b0;
    checkOutput("rb_oob_zero", 32'(obus.cfg_rdata), 32'd0);
`endif

    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = vecs[7];
    cycle();
    checkOutput("pre_rst_data", 32'(bus.out_data), 32'hF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(bus.out_data), 32'd0);
`ifdef LUT_READBACK_EN
    checkOutput("mid_rst_rdata", 32'(bus.cfg_rdata), 32'd0);
`endif
    applyStimulus(vecs[7], 4'b0000, "post_rst_lookup");
    applyStimulus({18'd0, 6'b100101}, 4'b0000, "post_rst_n0");
    oddLookup(2'd1, 6'b000000, "post_rst_odd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
